press_classifier: RTL and testbench

- Sits directly downstream of the push-button debouncer and consumes its press pulse.
- Classifies each button activity as a single press or a double press, using a programmable time window.
- Emits a one-cycle strobe per event.
- Maintains a 4-digit BCD press tally for the 7-segment display path: single press increments, double press decrements.

---
 rtl/press_pkg.sv | 9 +
 rtl/bcd_updown_counter.sv | 64 ++++++
 rtl/press_classifier.sv | 94 +++++++++
 tb/tb_press_classifier.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared types and constants for the press classifier and its BCD tally.
package press_pkg;

  typedef enum logic {IDLE, WAIT2} press_state_t;

  localparam int         BCD_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with ripple carry/borrow between digits.
// Wraps 9..9 <-> 0..0 by default; define PRESS_SAT_EN to saturate at both ends.
module bcd_updown_counter
  import press_pkg::*;
(
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    inc,
  input  logic                    dec,
  output logic [4*BCD_DIGITS-1:0] out
);

  logic [4*BCD_DIGITS-1:0] count_q;
  logic [4*BCD_DIGITS-1:0] count_nxt;
  logic                    carry;
  logic                    sat_hold;

`ifdef PRESS_SAT_EN
  assign sat_hold = (inc && (count_q == {BCD_DIGITS{BCD_MAX}})) ||
                    (dec && (count_q == '0));
`else
  assign sat_hold = 1'b0;
`endif

  // carry doubles as the borrow flag when counting down
  always_comb begin
    count_nxt = count_q;
    carry     = 1'b1;
    if (!sat_hold && inc && !dec) begin
      for (int i = 0; i < BCD_DIGITS; i++) begin
        if (carry) begin
          if (count_q[4*i +: 4] >= BCD_MAX) begin
            count_nxt[4*i +: 4] = 4'd0;
          end else begin
            count_nxt[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry               = 1'b0;
          end
        end
      end
    end else if (!sat_hold && dec && !inc) begin
      for (int i = 0; i < BCD_DIGITS; i++) begin
        if (carry) begin
          if (count_q[4*i +: 4] == 4'd0) begin
            count_nxt[4*i +: 4] = BCD_MAX;
          end else begin
            count_nxt[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            carry               = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

  assign out = count_q;

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button presses as single or double within DBL_WINDOW cycles
// and keeps a BCD tally (+1 single, -1 double). PRESS_SAT_EN makes the tally saturate.
module press_classifier
  import press_pkg::*;
#(
  parameter int DBL_WINDOW = 25_000_000,
  parameter int TMR_W      = $clog2(DBL_WINDOW)
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    btn_pulse,
  output logic                    single_o,
  output logic                    double_o,
  output logic                    busy_o,
  output logic [4*BCD_DIGITS-1:0] count_bcd
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DBL_WINDOW - 1);

  press_state_t     state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             btn_d;
  logic             primed;
  logic             press;
  logic             single_nxt;
  logic             double_nxt;

  // primed blocks the first cycle after reset so a button already held
  // at release is absorbed into btn_d instead of counting as a press
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      btn_d  <= 1'b0;
      primed <= 1'b0;
    end else begin
      btn_d  <= btn_pulse;
      primed <= 1'b1;
    end
  end

  assign press = btn_pulse & ~btn_d & primed;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= IDLE;
      timer    <= '0;
      single_o <= 1'b0;
      double_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      single_o <= single_nxt;
      double_o <= double_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt = WAIT2;
          timer_nxt = '0;
        end
      end
      WAIT2: begin
        if (press) begin
          state_nxt  = IDLE;
          timer_nxt  = '0;
          double_nxt = 1'b1;
        end else if (timer == TMR_LAST) begin
          state_nxt  = IDLE;
          timer_nxt  = '0;
          single_nxt = 1'b1;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
    endcase
  end

  assign busy_o = (state == WAIT2);

  bcd_updown_counter u_counter (
    .clk   (clk),
    .res_n (res_n),
    .inc   (single_o),
    .dec   (double_o),
    .out   (count_bcd)
  );

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with DBL_WINDOW=16; counts relative to the
// cycle in which the first press is driven. Expected tallies follow PRESS_SAT_EN.
module tb_press_classifier;

  logic        clk = 1'b0;
  logic        res_n;
  logic        btn_pulse;
  logic        single_o;
  logic        double_o;
  logic        busy_o;
  logic [15:0] count_bcd;

  int checks = 0;
  int errors = 0;

  int          single_cnt;
  int          double_cnt;
  int          first_single;
  int          first_double;
  logic        busy_log  [64];
  logic [15:0] count_log [64];
  int          hits;

`ifdef PRESS_SAT_EN
  localparam logic [15:0] C_C  = 16'h0000, C_D  = 16'h0001, C_E = 16'h0000;
  localparam logic [15:0] C_F1 = 16'h0001, C_F2 = 16'h0002, C_G = 16'h0003;
  localparam logic [15:0] C_H  = 16'h0011, C_H2 = 16'h0010;
`else
  localparam logic [15:0] C_C  = 16'h9999, C_D  = 16'h0000, C_E = 16'h9999;
  localparam logic [15:0] C_F1 = 16'h0000, C_F2 = 16'h0001, C_G = 16'h0002;
  localparam logic [15:0] C_H  = 16'h0010, C_H2 = 16'h0009;
`endif

  press_classifier #(.DBL_WINDOW(16)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .btn_pulse (btn_pulse),
    .single_o  (single_o),
    .double_o  (double_o),
    .busy_o    (busy_o),
    .count_bcd (count_bcd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives a first pulse at cycle 0 and an optional second pulse at cycle gap2,
  // logging the outputs seen during each cycle of the window.
  task automatic applyStimulus(input int p1_len, input int gap2, input int p2_len,
                               input int ncycles);
    single_cnt   = 0;
    double_cnt   = 0;
    first_single = -1;
    first_double = -1;
    for (int k = 0; k < ncycles; k++) begin
      busy_log[k]  = busy_o;
      count_log[k] = count_bcd;
      if (single_o) begin
        single_cnt++;
        if (first_single < 0) first_single = k;
      end
      if (double_o) begin
        double_cnt++;
        if (first_double < 0) first_double = k;
      end
      btn_pulse = (k < p1_len) || (gap2 > 0 && k >= gap2 && k < gap2 + p2_len);
      step();
    end
    btn_pulse = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    res_n     = 1'b0;
    btn_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("reset_strobes_busy", {13'd0, single_o, double_o, busy_o}, 16'h0000);
    checkOutput("reset_count", count_bcd, 16'h0000);
    res_n = 1'b1;
    repeat (2) step();

    $display("[TB] single press, 5-cycle pulse");
    applyStimulus(5, 0, 0, 20);
    checkOutput("single_at", 16'(first_single), 16'd17);
    checkOutput("single_cnt", 16'(single_cnt), 16'd1);
    checkOutput("single_no_double", 16'(double_cnt), 16'd0);
    checkOutput("busy_before", {15'd0, busy_log[0]}, 16'd0);
    checkOutput("busy_first", {15'd0, busy_log[1]}, 16'd1);
    checkOutput("busy_last", {15'd0, busy_log[16]}, 16'd1);
    checkOutput("busy_after", {15'd0, busy_log[17]}, 16'd0);
    checkOutput("count_at_strobe", count_log[17], 16'h0000);
    checkOutput("count_after_single", count_log[18], 16'h0001);

    $display("[TB] double press, gap 8");
    applyStimulus(3, 8, 2, 30);
    checkOutput("double_at", 16'(first_double), 16'd9);
    checkOutput("double_cnt", 16'(double_cnt), 16'd1);
    checkOutput("double_no_single", 16'(single_cnt), 16'd0);
    checkOutput("double_busy_end", {15'd0, busy_log[9]}, 16'd0);
    checkOutput("count_after_double", count_log[10], 16'h0000);

    $display("[TB] double from zero");
    applyStimulus(3, 8, 2, 12);
    checkOutput("zero_minus_one", count_log[10], C_C);

    $display("[TB] single from top");
    applyStimulus(1, 0, 0, 20);
    checkOutput("top_plus_one", count_log[18], C_D);

    $display("[TB] second press at timer 15");
    applyStimulus(2, 16, 1, 24);
    checkOutput("edge_busy", {15'd0, busy_log[16]}, 16'd1);
    checkOutput("edge_double_at", 16'(first_double), 16'd17);
    checkOutput("edge_no_single", 16'(single_cnt), 16'd0);
    checkOutput("edge_count", count_log[18], C_E);

    $display("[TB] second press one cycle late");
    applyStimulus(2, 17, 1, 40);
    checkOutput("late_single_at", 16'(first_single), 16'd17);
    checkOutput("late_single_cnt", 16'(single_cnt), 16'd2);
    checkOutput("late_no_double", 16'(double_cnt), 16'd0);
    checkOutput("late_rearm_busy", {15'd0, busy_log[18]}, 16'd1);
    checkOutput("late_count1", count_log[18], C_F1);
    checkOutput("late_count2", count_log[35], C_F2);

    $display("[TB] long held input");
    applyStimulus(40, 0, 0, 45);
    checkOutput("held_single_cnt", 16'(single_cnt), 16'd1);
    checkOutput("held_single_at", 16'(first_single), 16'd17);
    checkOutput("held_no_double", 16'(double_cnt), 16'd0);
    checkOutput("held_count", count_log[44], C_G);

    $display("[TB] carry and borrow across digits");
    hits = 0;
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1, 0, 0, 19);
      hits += single_cnt;
    end
    checkOutput("carry_singles", 16'(hits), 16'd8);
    checkOutput("carry_count", count_log[18], C_H);
    applyStimulus(3, 8, 2, 12);
    checkOutput("borrow_count", count_log[10], C_H2);

    $display("[TB] reset during WAIT2");
    btn_pulse = 1'b1;
    step();
    btn_pulse = 1'b0;
    repeat (7) step();
    checkOutput("pre_reset_busy", {15'd0, busy_o}, 16'd1);
    #2;
    res_n     = 1'b0;
    btn_pulse = 1'b1;
    #1;
    checkOutput("async_reset_outs", {13'd0, single_o, double_o, busy_o}, 16'h0000);
    checkOutput("async_reset_count", count_bcd, 16'h0000);
    repeat (2) @(posedge clk);
    #3;
    res_n = 1'b1;
    hits  = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy_o || single_o || double_o) hits++;
    end
    checkOutput("held_through_reset", 16'(hits), 16'd0);
    btn_pulse = 1'b0;
    step();
    btn_pulse = 1'b1;
    step();
    btn_pulse = 1'b0;
    checkOutput("retoggle_busy", {15'd0, busy_o}, 16'd1);
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (single_o) hits++;
    end
    checkOutput("retoggle_single_cnt", 16'(hits), 16'd1);
    checkOutput("retoggle_count", count_bcd, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
